// File: rtl/game_pkg.sv
// game_pkg: shared board geometry, tile exponent codes and spawner state encoding.
package game_pkg;
    localparam int CELL_W  = 4;
    localparam int N_CELLS = 16;
    localparam int BOARD_W = CELL_W * N_CELLS;
    localparam logic [CELL_W-1:0] EXP_EMPTY = 4'd0;
    localparam logic [CELL_W-1:0] EXP_TWO   = 4'd1;
    localparam logic [CELL_W-1:0] EXP_FOUR  = 4'd2;
    typedef logic [N_CELLS-1:0][CELL_W-1:0] board_t;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SCAN, S_DONE, S_FULL} spawn_state_e;
endpackage

// File: rtl/tile_spawner_if.sv
// tile_spawner_if: request/board/random-block/result signals of the tile spawner.
interface tile_spawner_if;
    import game_pkg::*;
    logic               spawn_req;
    logic [BOARD_W-1:0] board;
    logic [3:0]         rand_pos;
    logic [3:0]         rand_val;
    logic               get;
    logic               busy;
    logic               spawn_valid;
    logic [3:0]         spawn_pos;
    logic [3:0]         spawn_exp;
    logic               board_full;
    modport slave  (input  spawn_req, board, rand_pos, rand_val,
                    output get, busy, spawn_valid, spawn_pos, spawn_exp, board_full);
    modport master (output spawn_req, board, rand_pos, rand_val,
                    input  get, busy, spawn_valid, spawn_pos, spawn_exp, board_full);
endinterface

// File: rtl/tile_spawner.sv
// tile_spawner: picks the first empty cell from a random start (wrapping) and a tile exponent.
// Define TILE_SPAWN_FOUR_EN to allow exponent 2 (tile 4) when rand_val < FOUR_THRESH.
module tile_spawner
    import game_pkg::*;
#(
    parameter int FOUR_THRESH = 2
) (
    input  logic           clk,
    input  logic           reset_debounced,
    tile_spawner_if.slave  bus
);
    spawn_state_e state_q, state_d;
    board_t       snap_q, snap_d;
    logic [3:0]   ptr_q, ptr_d, cnt_q, cnt_d;
    logic [3:0]   choice_q, choice_d, pos_q, pos_d, exp_q, exp_d;
    logic [3:0]   choice_new;

`ifdef TILE_SPAWN_FOUR_EN
    assign choice_new = (int'(bus.rand_val) < FOUR_THRESH) ? EXP_FOUR : EXP_TWO;
`else
    logic unused_rand;
    assign unused_rand = ^{bus.rand_val, 4'(FOUR_THRESH)};
    assign choice_new  = EXP_TWO;
`endif

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        choice_d = choice_q;
        pos_d    = pos_q;
        exp_d    = exp_q;
        case (state_q)
            S_IDLE: if (bus.spawn_req) begin
                snap_d  = bus.board;
                state_d = S_REQ;
            end
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                ptr_d    = bus.rand_pos;
                cnt_d    = 4'd0;
                choice_d = choice_new;
                state_d  = S_SCAN;
            end
            S_SCAN: begin
                if (snap_q[ptr_q] == EXP_EMPTY) begin
                    pos_d   = ptr_q;
                    exp_d   = choice_q;
                    state_d = S_DONE;
                end else if (cnt_q == 4'(N_CELLS - 1)) begin
                    state_d = S_FULL;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_debounced) begin
            state_q  <= S_IDLE;
            snap_q   <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            choice_q <= '0;
            pos_q    <= '0;
            exp_q    <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            choice_q <= choice_d;
            pos_q    <= pos_d;
            exp_q    <= exp_d;
        end
    end

    assign bus.get         = (state_q == S_REQ);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.spawn_valid = (state_q == S_DONE);
    assign bus.board_full  = (state_q == S_FULL);
    assign bus.spawn_pos   = pos_q;
    assign bus.spawn_exp   = exp_q;
endmodule

// File: tb/tb_tile_spawner.sv
// tb_tile_spawner: random and directed spawns checked cycle by cycle against a behavioural model.
module tb_tile_spawner;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset_debounced;
    tile_spawner_if bus();

    tile_spawner #(.FOUR_THRESH(2)) dut (
        .clk             (clk),
        .reset_debounced (reset_debounced),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    logic e_get, e_busy, e_valid, e_full;
    logic [3:0] e_pos, e_exp;
    logic [3:0] held_pos = 4'd0, held_exp = 4'd0;

    function automatic void chk(string name, logic [11:0] act, logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    // Packed as {get, busy, spawn_valid, board_full, spawn_pos, spawn_exp}
    always @(negedge clk)
        if (chk_en)
            chk("cycle_outputs",
                {bus.get, bus.busy, bus.spawn_valid, bus.board_full, bus.spawn_pos, bus.spawn_exp},
                {e_get, e_busy, e_valid, e_full, e_pos, e_exp});

    // Number of occupied cells probed before the first empty one; 16 means full.
    function automatic int first_empty_k(logic [63:0] b, logic [3:0] p);
        for (int i = 0; i < 16; i++) begin
            int c;
            c = (int'(p) + i) % 16;
            if (b[c*4 +: 4] == 4'd0) return i;
        end
        return 16;
    endfunction

    function automatic logic [3:0] model_exp(logic [3:0] v);
`ifdef TILE_SPAWN_FOUR_EN
        return (v < 4'd2) ? 4'd2 : 4'd1;
`else
        return (v == v) ? 4'd1 : 4'd1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(logic g, logic bz, logic v, logic f);
        e_get = g; e_busy = bz; e_valid = v; e_full = f;
        e_pos = held_pos; e_exp = held_exp;
    endtask

    task automatic garbage();
        bus.rand_pos = 4'($urandom);
        bus.rand_val = 4'($urandom);
    endtask

    task automatic idle_cycles(int n);
        for (int i = 0; i < n; i++) begin
            bus.spawn_req = 1'b0;
            garbage();
            expect_out(0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic spawn(input logic [63:0] b, input logic [3:0] p, input logic [3:0] v, output int d);
        int  k;
        bit  full;
        k    = first_empty_k(b, p);
        full = (k == 16);
        d    = full ? 18 : 3 + k;
        bus.spawn_req = 1'b1;
        bus.board     = b;
        garbage();
        expect_out(0, 0, 0, 0);
        tick();
        for (int c = 0; c <= d; c++) begin
            bus.spawn_req = 1'($urandom_range(0, 1));
            bus.board     = {$urandom, $urandom};
            if (c == 1) begin
                bus.rand_pos = p;
                bus.rand_val = v;
            end else garbage();
            if (c == d && !full) begin
                held_pos = 4'(int'(p) + k);
                held_exp = model_exp(v);
            end
            expect_out(c == 0, 1, c == d && !full, c == d && full);
            tick();
        end
    endtask

    function automatic logic [63:0] occupy(int lo, int hi, logic [63:0] base);
        logic [63:0] b;
        b = base;
        for (int i = lo; i <= hi; i++) b[i*4 +: 4] = 4'd3;
        return b;
    endfunction

    function automatic logic [63:0] rand_board(int density);
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < 16; i++)
            if ($urandom_range(0, 99) < density) b[i*4 +: 4] = 4'($urandom_range(1, 11));
        return b;
    endfunction

    initial begin
        int d;
        reset_debounced = 1'b1;
        bus.spawn_req   = 1'b0;
        bus.board       = '0;
        bus.rand_pos    = '0;
        bus.rand_val    = '0;
        repeat (2) tick();
        expect_out(0, 0, 0, 0);
        chk_en = 1'b1;
        tick();
        reset_debounced = 1'b0;
        idle_cycles(2);

        // Empty board from cell 5.
        chk("lit_k_empty", 12'(first_empty_k(64'd0, 4'd5)), 12'd0);
        spawn(64'd0, 4'd5, 4'd7, d);
        chk("lit_lat_empty", 12'(d), 12'd3);
        chk("lit_pos_empty", {bus.spawn_pos, bus.spawn_exp}, {4'd5, 4'd1});
        idle_cycles(1);

        // Cells 5..9 occupied: five extra probe cycles.
        chk("lit_k_run", 12'(first_empty_k(occupy(5, 9, 64'd0), 4'd5)), 12'd5);
        spawn(occupy(5, 9, 64'd0), 4'd5, 4'd9, d);
        chk("lit_lat_run", 12'(d), 12'd8);
        chk("lit_pos_run", {bus.spawn_pos, bus.spawn_exp}, {4'd10, 4'd1});
        idle_cycles(1);

        // Wrap from 14 past 15 to 0.
        spawn(occupy(14, 15, 64'd0), 4'd14, 4'd5, d);
        chk("lit_pos_wrap", {bus.spawn_pos, bus.spawn_exp}, {4'd0, 4'd1});
        idle_cycles(1);

        // Full board: board_full after 18 cycles, result registers untouched.
        spawn(occupy(0, 15, 64'd0), 4'd3, 4'd0, d);
        chk("lit_lat_full", 12'(d), 12'd18);
        chk("lit_pos_full", {bus.spawn_pos, bus.spawn_exp}, {4'd0, 4'd1});
        idle_cycles(1);

        // rand_val = 0 selects a tile 4 only when the feature is built in.
        spawn(64'd0, 4'd9, 4'd0, d);
`ifdef TILE_SPAWN_FOUR_EN
        chk("lit_exp_four", {bus.spawn_pos, bus.spawn_exp}, {4'd9, 4'd2});
`else
        chk("lit_exp_four", {bus.spawn_pos, bus.spawn_exp}, {4'd9, 4'd1});
`endif

        // Back-to-back requests with no idle gap.
        spawn(rand_board(50), 4'($urandom), 4'($urandom), d);
        spawn(rand_board(50), 4'($urandom), 4'($urandom), d);
        idle_cycles(1);

        // Reset during SCAN aborts with no pulse and clears the result registers.
        bus.spawn_req = 1'b1;
        bus.board     = occupy(0, 15, 64'd0);
        expect_out(0, 0, 0, 0);
        tick();
        for (int c = 0; c <= 5; c++) begin
            bus.spawn_req = 1'b0;
            if (c == 1) bus.rand_pos = 4'd2; else garbage();
            expect_out(c == 0, 1, 0, 0);
            reset_debounced = (c == 5);
            tick();
        end
        reset_debounced = 1'b0;
        held_pos = 4'd0;
        held_exp = 4'd0;
        idle_cycles(3);

        for (int t = 0; t < 60; t++) begin
            spawn(rand_board($urandom_range(0, 100)), 4'($urandom), 4'($urandom), d);
            idle_cycles($urandom_range(0, 2));
        end
        spawn(occupy(0, 15, 64'd0), 4'($urandom), 4'($urandom), d);
        idle_cycles(2);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tile_spawner.md
# tile_spawner

Places a new tile on the 4x4 board after each move in the 2048 datapath. Sits directly downstream of the random-number block. It pulses `get`, consumes the two 4-bit random values, and probes the board from the random start cell, wrapping, until it finds an empty cell. It reports the chosen position and tile exponent, or reports that the board is full.

## Interface
Parameters:
- `FOUR_THRESH`, default 2: a tile of value 4 is spawned when `rand_val < FOUR_THRESH` (probability 2/16).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_debounced`  in  1  synchronous, active-high reset.
- `spawn_req`  in  1  single-cycle request; accepted only in IDLE.
- `board`  in  64  16 cells x 4-bit exponent; cell i = bits [4i+3:4i]; 0 = empty.
- `rand_pos`  in  4  random value from the random block (its out1).
- `rand_val`  in  4  random value from the random block (its out2).
- `get`  out  1  one-cycle pulse to the random block.
- `busy`  out  1  high from request acceptance until the DONE/FULL cycle ends.
- `spawn_valid`  out  1  one-cycle pulse; `spawn_pos` and `spawn_exp` are valid.
- `spawn_pos`  out  4  chosen cell index; held until the next `spawn_valid`.
- `spawn_exp`  out  4  tile exponent, 1 (tile 2) or 2 (tile 4); held.
- `board_full`  out  1  one-cycle pulse; no empty cell found.

## Operation
- FSM states: IDLE -> REQ -> WAIT -> SCAN -> DONE or FULL -> IDLE.
- IDLE: when `spawn_req`=1, latch `board` into a snapshot and go to REQ. Later board changes are ignored.
- REQ: `get`=1 for exactly this cycle. Go to WAIT.
- WAIT: the random block registers its outputs at the end of REQ. On exit: `ptr` <= `rand_pos`, `cnt` <= 0, exponent choice <= 2 if `rand_val < FOUR_THRESH`, otherwise 1. Go to SCAN.
- SCAN, one cell per cycle:
  - If snapshot[`ptr`]==0: `spawn_pos` <= `ptr`, `spawn_exp` <= choice, go to DONE.
  - Else if `cnt`==15: go to FULL.
  - Else `ptr` <= `ptr`+1 (4-bit, 15 wraps to 0) and `cnt` <= `cnt`+1.
- DONE: `spawn_valid`=1 for one cycle, then IDLE.
- FULL: `board_full`=1 for one cycle, then IDLE. `spawn_pos` and `spawn_exp` are unchanged.
- `spawn_req` outside IDLE is dropped; it is not queued.
- Reset: state IDLE. `get`, `busy`, `spawn_valid`, `board_full` = 0. `spawn_pos` = 0, `spawn_exp` = 0. Snapshot, `ptr`, `cnt` = 0.
- Reset mid-operation: abort and return to IDLE on the next edge, with no `spawn_valid` or `board_full` pulse.

## Timing
- Edge E0 accepts the request. `get` is high in cycle E0-E1. Random outputs are valid after E1. `ptr` is loaded at E2.
- Start cell empty: `spawn_valid` is high in cycle E3-E4 (4 cycles after acceptance).
- k occupied cells before the first empty one (k = 0..15): `spawn_valid` follows E3+k.
- Full board: `board_full` is high in cycle E18-E19.
- `busy` rises after E0 and falls after the DONE/FULL cycle. Back-to-back throughput: one spawn per at least 5 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `TILE_SPAWN_FOUR_EN` defined: exponent is 2 when `rand_val < FOUR_THRESH`, otherwise 1.
- Not defined: `spawn_exp` is always 1. `rand_val` is unused and the comparator is removed. Timing is identical.

## Structure
- Shared package `game_pkg` holds:
  - `CELL_W`=4, `N_CELLS`=16, `BOARD_W`=64
  - the spawner state enum
  - exponent constants `EXP_EMPTY`=0, `EXP_TWO`=1, `EXP_FOUR`=2
- No sub-module: the single-cell mux/compare is inline. The block connects directly to the random block's `get`/out1/out2.

## Test plan
- Empty board, `rand_pos`=5, `rand_val`=7 (FOUR_THRESH=2) -> one `get` pulse; `spawn_valid` in the 4th cycle after acceptance; pos=5, exp=1.
- Cells 5-9 occupied, `rand_pos`=5 -> pos=10; `spawn_valid` 5 cycles later than the empty case.
- Cells 14, 15 occupied, cell 0 empty, `rand_pos`=14 -> wrap; pos=0.
- All 16 cells non-zero -> `board_full` pulse after E18; no `spawn_valid`; `spawn_pos`/`spawn_exp` keep their previous values.
- `rand_val`=0: with `TILE_SPAWN_FOUR_EN` -> exp=2; without -> exp=1.
- `spawn_req` re-asserted while busy -> ignored, single `get`. `reset_debounced` in SCAN -> next cycle IDLE with all outputs 0 and no pulses.
